// File: rtl/dread.sv
// dread: walks the SDRAM sample ring from oldest to newest word under a credit limit
// and streams the returned words out through a first-word fall-through buffer.
// Optional feature macro: DREAD_ABORT_EN (rd_abort port plus FLUSH state).
module dread #(
   parameter int unsigned DEPTH = 16
) (
   input  logic        sdram_clk,
   input  logic        sdram_rst,
   input  logic        rd_start,
   input  logic [31:0] rd_start_idx,
   input  logic [31:0] rd_len,
   input  logic [31:0] sample_last_cnt,
   output logic        rd_req,
   output logic [31:0] rd_addr,
   input  logic        rd_valid,
   input  logic        rd_data_valid,
   input  logic [15:0] rd_data,
   output logic [15:0] dout,
   output logic        dout_valid,
   input  logic        dout_ready,
   output logic        rd_busy,
   output logic        rd_done,
   output logic        rd_err
`ifdef DREAD_ABORT_EN
   ,
   input  logic        rd_abort
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = CW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
`ifdef DREAD_ABORT_EN
      ,
      FLUSH = 2'd3
`endif
   } state_t;

   state_t        state;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] fifo_cnt;
   logic [31:0]   remaining;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [15:0]   mem [DEPTH];

   logic          abort_c;
   logic          discard_c;
   logic [SW-1:0] inflight_c;
   logic          accept_c;
   logic          ret_ok_c;
   logic          push_c;
   logic          pop_c;
   logic [CW-1:0] out_nxt;
   logic [CW-1:0] cnt_nxt;
   logic          unused_idx_c;

   // Abort gates the request in the same cycle; returns are dropped while flushing.
`ifdef DREAD_ABORT_EN
   assign abort_c   = rd_abort & ((state == ISSUE) | (state == DRAIN));
   assign discard_c = abort_c | (state == FLUSH);
`else
   assign abort_c   = 1'b0;
   assign discard_c = 1'b0;
`endif

   assign inflight_c = SW'(outstanding) + SW'(fifo_cnt);
   assign rd_req     = (state == ISSUE) & (inflight_c < SW'(DEPTH)) & ~abort_c;
   assign accept_c   = rd_req & rd_valid;
   assign ret_ok_c   = rd_data_valid & (outstanding != '0);
   assign push_c     = ret_ok_c & ~discard_c;
   assign pop_c      = dout_valid & dout_ready;

   assign dout_valid   = (fifo_cnt != '0);
   assign dout         = mem[rd_ptr];
   assign rd_busy      = (state != IDLE);
   assign unused_idx_c = ^rd_start_idx[31:30];

   // Next counter values; simultaneous increment and decrement cancel.
   always_comb begin
      out_nxt = outstanding;
      if (accept_c && !ret_ok_c)
         out_nxt = outstanding + CW'(1);
      else if (!accept_c && ret_ok_c)
         out_nxt = outstanding - CW'(1);
      cnt_nxt = fifo_cnt;
      if (push_c && !pop_c)
         cnt_nxt = fifo_cnt + CW'(1);
      else if (!push_c && pop_c)
         cnt_nxt = fifo_cnt - CW'(1);
   end

   always_ff @(posedge sdram_clk) begin
      if (sdram_rst) begin
         state       <= IDLE;
         rd_addr     <= '0;
         remaining   <= '0;
         outstanding <= '0;
         fifo_cnt    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         rd_done     <= 1'b0;
         rd_err      <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++)
            mem[i] <= '0;
      end else begin
         rd_done     <= 1'b0;
         outstanding <= out_nxt;
         if (rd_data_valid && (outstanding == '0))
            rd_err <= 1'b1;

         if (abort_c) begin
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
         end else begin
            fifo_cnt <= cnt_nxt;
            if (push_c) begin
               mem[wr_ptr] <= rd_data;
               wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c)
               rd_ptr <= rd_ptr + AW'(1);
         end

         // Ring walk: wrap to index 0 after the last ring word.
         if (accept_c) begin
            remaining <= remaining - 32'd1;
            if ({2'b00, rd_addr[31:2]} == sample_last_cnt)
               rd_addr <= '0;
            else
               rd_addr <= rd_addr + 32'd4;
         end

         case (state)
            IDLE: begin
               if (rd_start) begin
                  if (rd_len != 32'd0) begin
                     remaining <= rd_len;
                     rd_addr   <= {rd_start_idx[29:0], 2'b00};
                     state     <= ISSUE;
                  end else begin
                     rd_done <= 1'b1;
                  end
               end
            end
            ISSUE: begin
`ifdef DREAD_ABORT_EN
               if (abort_c)
                  state <= FLUSH;
               else
`endif
               if (accept_c && (remaining == 32'd1))
                  state <= DRAIN;
            end
            DRAIN: begin
`ifdef DREAD_ABORT_EN
               if (abort_c)
                  state <= FLUSH;
               else
`endif
               if ((out_nxt == '0) && (cnt_nxt == '0)) begin
                  rd_done <= 1'b1;
                  state   <= IDLE;
               end
            end
`ifdef DREAD_ABORT_EN
            FLUSH: begin
               if (outstanding == '0)
                  state <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dread.sv
// Bench for dread: table-driven and randomized read-outs against an SDRAM return model
// and a ring-walk reference computed with modulo arithmetic.
module tb_dread;

   localparam int DEPTH = 16;

   logic        sdram_clk = 1'b0;
   logic        sdram_rst;
   logic        rd_start;
   logic [31:0] rd_start_idx;
   logic [31:0] rd_len;
   logic [31:0] sample_last_cnt;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic        rd_valid;
   logic        rd_data_valid;
   logic [15:0] rd_data;
   logic [15:0] dout;
   logic        dout_valid;
   logic        dout_ready;
   logic        rd_busy;
   logic        rd_done;
   logic        rd_err;
`ifdef DREAD_ABORT_EN
   logic        rd_abort;
   bit          abort_now = 1'b0;
`endif

   dread #(.DEPTH(DEPTH)) dut (
      .sdram_clk(sdram_clk),
      .sdram_rst(sdram_rst),
      .rd_start(rd_start),
      .rd_start_idx(rd_start_idx),
      .rd_len(rd_len),
      .sample_last_cnt(sample_last_cnt),
      .rd_req(rd_req),
      .rd_addr(rd_addr),
      .rd_valid(rd_valid),
      .rd_data_valid(rd_data_valid),
      .rd_data(rd_data),
      .dout(dout),
      .dout_valid(dout_valid),
      .dout_ready(dout_ready),
      .rd_busy(rd_busy),
      .rd_done(rd_done),
      .rd_err(rd_err)
`ifdef DREAD_ABORT_EN
      ,
      .rd_abort(rd_abort)
`endif
   );

   always #5 sdram_clk = ~sdram_clk;

   typedef struct {
      logic [31:0] idx;
      logic [31:0] len;
      logic [31:0] last;
      int          lat;
      int          vp;
      int          rp;
      int          exp_words;
      int          exp_dones;
   } vec_t;

   int checks = 0;
   int passes = 0;

   int cyc = 0;
   int lat = 3;
   int vp = 100;
   int rp = 100;
   bit rst_now = 1'b0;
   bit pend_start = 1'b0;
   bit ready_hold = 1'b0;
   bit inject_ret = 1'b0;
   bit exp_err = 1'b0;

   logic [31:0] exp_addr[$];
   logic [15:0] exp_data[$];
   logic [31:0] ret_addr[$];
   int          ret_due[$];

   int acc_cnt, pop_cnt, done_cnt, spurious;
   int start_cyc = -10;
   int done_cyc, last_pop_cyc;
   bit first_req, first_busy, busy_seen, req_seen;

   // SDRAM contents: a distinct word per ring index.
   function automatic logic [15:0] word_of(input logic [31:0] a);
      logic [31:0] i;
      i = a >> 2;
      return 16'(i * 32'd40503 + 32'd4660);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp)
         passes++;
      else
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // One clock: drive inputs after the falling edge, then sample and score.
   task automatic cycle();
      @(negedge sdram_clk);
      cyc++;
      sdram_rst  = rst_now;
      rd_start   = pend_start;
      pend_start = 1'b0;
      rd_valid   = ($urandom_range(99) < vp);
      dout_ready = !ready_hold && ($urandom_range(99) < rp);
`ifdef DREAD_ABORT_EN
      rd_abort   = abort_now;
`endif
      if (inject_ret) begin
         rd_data_valid = 1'b1;
         rd_data       = 16'hDEAD;
         inject_ret    = 1'b0;
      end else if (ret_due.size() != 0 && ret_due[0] <= cyc) begin
         rd_data_valid = 1'b1;
         rd_data       = word_of(ret_addr.pop_front());
         void'(ret_due.pop_front());
      end else begin
         rd_data_valid = 1'b0;
         rd_data       = '0;
      end
      #1;
      if (!sdram_rst) begin
         if (cyc == start_cyc + 1) begin
            first_req  = rd_req;
            first_busy = rd_busy;
         end
         if (rd_req && rd_valid) begin
            acc_cnt++;
            if (exp_addr.size() == 0)
               spurious++;
            else
               check("rd_addr", rd_addr, exp_addr.pop_front());
            ret_addr.push_back(rd_addr);
            ret_due.push_back(cyc + lat);
            check("credit", ((acc_cnt - pop_cnt) <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
         end
         if (dout_valid && dout_ready) begin
            pop_cnt++;
            last_pop_cyc = cyc;
            if (exp_data.size() == 0)
               spurious++;
            else
               check("dout", 32'(dout), 32'(exp_data.pop_front()));
         end
         if (rd_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (rd_busy) busy_seen = 1'b1;
         if (rd_req)  req_seen  = 1'b1;
      end
   endtask

   // Reference: word k of a read-out is ring index (start + k) mod (last + 1).
   task automatic begin_readout(input logic [31:0] idx, input logic [31:0] len,
                                input logic [31:0] last, input int lat_i,
                                input int vp_i, input int rp_i);
      exp_addr.delete();
      exp_data.delete();
      for (longint k = 0; k < longint'(len); k++) begin
         longint i;
         i = (longint'(idx) + k) % (longint'(last) + 1);
         exp_addr.push_back(32'(i * 4));
         exp_data.push_back(word_of(32'(i * 4)));
      end
      acc_cnt = 0; pop_cnt = 0; done_cnt = 0; spurious = 0;
      done_cyc = -1; last_pop_cyc = -1;
      busy_seen = 1'b0; req_seen = 1'b0; first_req = 1'b0; first_busy = 1'b0;
      rd_start_idx = idx; rd_len = len; sample_last_cnt = last;
      lat = lat_i; vp = vp_i; rp = rp_i;
      pend_start = 1'b1;
      start_cyc  = cyc + 1;
   endtask

   task automatic finish_readout(input int exp_words, input int exp_dones, input int budget);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         cycle();
         n++;
      end
      repeat (3) cycle();
      check("words", 32'(pop_cnt), 32'(exp_words));
      check("done_cnt", 32'(done_cnt), 32'(exp_dones));
      check("spurious", 32'(spurious), 32'd0);
      check("done_timing", 32'(done_cyc),
            (exp_words == 0) ? 32'(start_cyc + 1) : 32'(last_pop_cyc + 1));
      check("busy_after", 32'(rd_busy), 32'd0);
      check("rd_err", 32'(rd_err), 32'(exp_err));
      if (exp_words != 0)
         check("first_req_busy", {30'd0, first_busy, first_req}, 32'd3);
      else
         check("len0_quiet", {30'd0, busy_seen, req_seen}, 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rd_req"}, 32'(rd_req), 32'd0);
      check({tag, "_rd_addr"}, rd_addr, 32'd0);
      check({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
      check({tag, "_dout"}, 32'(dout), 32'd0);
      check({tag, "_rd_busy"}, 32'(rd_busy), 32'd0);
      check({tag, "_rd_done"}, 32'(rd_done), 32'd0);
      check({tag, "_rd_err"}, 32'(rd_err), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      vec_t vecs[6];
      int   n;

      sdram_rst = 1'b1; rd_start = 1'b0; rd_start_idx = '0; rd_len = '0;
      sample_last_cnt = 32'd1023; rd_valid = 1'b0; rd_data_valid = 1'b0;
      rd_data = '0; dout_ready = 1'b0;
`ifdef DREAD_ABORT_EN
      rd_abort = 1'b0;
`endif

      rst_now = 1'b1;
      cycle();
      cycle();
      check_reset_values("reset");
      rst_now = 1'b0;
      cycle();

      vecs[0] = '{32'd0,    32'd8,  32'd1023, 3, 100, 100, 8,  1};
      vecs[1] = '{32'd1022, 32'd4,  32'd1023, 3, 100, 100, 4,  1};
      vecs[2] = '{32'd0,    32'd0,  32'd1023, 3, 100, 100, 0,  1};
      vecs[3] = '{32'd5,    32'd20, 32'd7,    2, 60,  50,  20, 1};
      vecs[4] = '{32'd100,  32'd37, 32'd127,  5, 70,  30,  37, 1};
      vecs[5] = '{32'd0,    32'd1,  32'd0,    1, 100, 100, 1,  1};
      for (int v = 0; v < 6; v++) begin
         begin_readout(vecs[v].idx, vecs[v].len, vecs[v].last,
                       vecs[v].lat, vecs[v].vp, vecs[v].rp);
         finish_readout(vecs[v].exp_words, vecs[v].exp_dones, 2000);
      end

      for (int r = 0; r < 6; r++) begin
         logic [31:0] last, idx, len;
         last = 32'($urandom_range(300, 1));
         idx  = 32'($urandom_range(int'(last), 0));
         len  = 32'($urandom_range(60, 1));
         begin_readout(idx, len, last, int'($urandom_range(6, 1)),
                       int'($urandom_range(100, 20)), int'($urandom_range(100, 20)));
         finish_readout(int'(len), 1, 3000);
      end

      // Back-pressure: the credit limit caps issue at DEPTH words.
      begin_readout(32'd0, 32'd40, 32'd1023, 3, 100, 100);
      ready_hold = 1'b1;
      repeat (40) cycle();
      check("bp_accepts", 32'(acc_cnt), 32'(DEPTH));
      check("bp_rd_req", 32'(rd_req), 32'd0);
      check("bp_dout_valid", 32'(dout_valid), 32'd1);
      ready_hold = 1'b0;
      finish_readout(40, 1, 2000);

      // A second start while busy must not disturb the read-out in progress.
      begin_readout(32'd10, 32'd10, 32'd63, 2, 100, 100);
      repeat (3) cycle();
      rd_start_idx = 32'd500;
      rd_len       = 32'd3;
      pend_start   = 1'b1;
      finish_readout(10, 1, 500);

      // Unexpected return while idle: sticky error, nothing buffered.
      inject_ret = 1'b1;
      cycle();
      cycle();
      check("err_set", 32'(rd_err), 32'd1);
      check("err_dout_valid", 32'(dout_valid), 32'd0);
      repeat (5) cycle();
      check("err_sticky", 32'(rd_err), 32'd1);
      exp_err = 1'b1;
      begin_readout(32'd3, 32'd6, 32'd15, 2, 80, 80);
      finish_readout(6, 1, 500);

      // Reset in the middle of a read-out; sdramc is reset alongside.
      begin_readout(32'd0, 32'd30, 32'd1023, 3, 100, 100);
      repeat (6) cycle();
      rst_now = 1'b1;
      cycle();
      rst_now = 1'b0;
      ret_addr.delete();
      ret_due.delete();
      cycle();
      check_reset_values("midrst");
      exp_err = 1'b0;
      begin_readout(32'd7, 32'd5, 32'd15, 1, 100, 100);
      finish_readout(5, 1, 500);

`ifdef DREAD_ABORT_EN
      begin_readout(32'd0, 32'd20, 32'd1023, 3, 100, 0);
      ready_hold = 1'b1;
      n = 0;
      while (acc_cnt < 5 && n < 50) begin
         cycle();
         n++;
      end
      abort_now = 1'b1;
      cycle();
      check("abort_rd_req", 32'(rd_req), 32'd0);
      abort_now = 1'b0;
      repeat (10) cycle();
      check("abort_busy", 32'(rd_busy), 32'd0);
      check("abort_dout_valid", 32'(dout_valid), 32'd0);
      check("abort_no_done", 32'(done_cnt), 32'd0);
      check("abort_accepts", 32'(acc_cnt), 32'd5);
      check("abort_err", 32'(rd_err), 32'd0);
      ready_hold = 1'b0;
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
